// File: rtl/q2_panel_loader_if.sv
// q2_panel_loader_if: valid/ready word stream from the host loader into the panel sequencer
// Signals:
//   in_valid  host -> loader  word available
//   in_ready  loader -> host  word accepted this cycle
//   in_data   host -> loader  12-bit word to deposit
//   in_last   host -> loader  final word of the program
interface q2_panel_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        in_last;
    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/q2_panel_loader.sv
// q2_panel_loader: drives the q2 front-panel switches with timed strobes to deposit a word stream
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   s_in            word stream (slave side of q2_panel_loader_if)
//   i_stop_req      level request to halt q2 or abort a load
//   i_run           q2 run flag; blocks new words while high
//   o_sw            panel data switches
//   o_dep_sw        deposit strobe
//   o_incp_sw       increment-P strobe
//   o_start_sw      start strobe
//   o_stop_sw       stop strobe
//   o_busy          high outside IDLE
//   o_count         words deposited since the last restart, wraps at 12 bits
//   o_done          one-cycle pulse when a load sequence completes
module q2_panel_loader #(
    parameter int PULSE_CYC  = 16,
    parameter int GAP_CYC    = 16,
    parameter int SETUP_CYC  = 4,
    parameter int CNT_W      = 8,
    parameter bit AUTO_START = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    q2_panel_loader_if.slave   s_in,
    input  logic               i_stop_req,
    input  logic               i_run,
    output logic [11:0]        o_sw,
    output logic               o_dep_sw,
    output logic               o_incp_sw,
    output logic               o_start_sw,
    output logic               o_stop_sw,
    output logic               o_busy,
    output logic [11:0]        o_count,
    output logic               o_done
);
    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_DEP, S_GAP1, S_INC, S_GAP2, S_START, S_STOP, S_SGAP
    } state_t;

    localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, w_load;
    logic             r_last, r_clr;
    logic             w_xfer, w_exp, w_stop, w_done, w_enter;

    assign s_in.in_ready = (r_state == S_IDLE) & ~i_run & ~i_stop_req & ~rst;
    assign w_xfer        = s_in.in_valid & s_in.in_ready;
    assign w_exp         = r_cnt == '0;
    assign w_stop        = i_stop_req & (r_state != S_STOP) & (r_state != S_SGAP);
    assign w_enter       = w_next != r_state;

    // Stop has priority over every dwell; done is only raised on a normal completion.
    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        if (w_stop)
            w_next = S_STOP;
        else
            case (r_state)
                S_IDLE:  w_next = w_xfer ? S_SETUP : S_IDLE;
                S_SETUP: w_next = w_exp ? S_DEP : S_SETUP;
                S_DEP:   w_next = w_exp ? S_GAP1 : S_DEP;
                S_GAP1:  w_next = w_exp ? S_INC : S_GAP1;
                S_INC:   w_next = w_exp ? S_GAP2 : S_INC;
                S_GAP2: begin
                    w_next = !w_exp ? S_GAP2 : (r_last && AUTO_START) ? S_START : S_IDLE;
                    w_done = w_exp && r_last && !AUTO_START;
                end
                S_START: begin
                    w_next = w_exp ? S_IDLE : S_START;
                    w_done = w_exp;
                end
                S_STOP:  w_next = w_exp ? S_SGAP : S_STOP;
                S_SGAP:  w_next = w_exp ? S_IDLE : S_SGAP;
                default: w_next = S_IDLE;
            endcase
    end

    // Dwell of the state being entered, minus one; the state exits when the counter hits 0.
    assign w_load = (w_next == S_SETUP) ? L_SETUP :
                    (w_next inside {S_DEP, S_INC, S_START, S_STOP}) ? L_PULSE : L_GAP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last     <= 1'b0;
            r_clr      <= 1'b0;
            o_sw       <= '0;
            o_dep_sw   <= 1'b0;
            o_incp_sw  <= 1'b0;
            o_start_sw <= 1'b0;
            o_stop_sw  <= 1'b0;
            o_busy     <= 1'b0;
            o_count    <= '0;
            o_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_enter ? w_load : r_cnt - 1'b1;
            if (w_xfer) begin
                o_sw   <= s_in.in_data;
                r_last <= s_in.in_last;
            end
            // count restarts on the first transfer after a done or an abort
            o_count    <= (w_xfer && r_clr) ? '0 :
                          (w_enter && w_next == S_GAP2) ? o_count + 12'd1 : o_count;
            r_clr      <= (w_done || (w_enter && w_next == S_STOP)) ? 1'b1 : w_xfer ? 1'b0 : r_clr;
            o_dep_sw   <= w_next == S_DEP;
            o_incp_sw  <= w_next == S_INC;
            o_start_sw <= w_next == S_START;
            o_stop_sw  <= w_next == S_STOP;
            o_busy     <= w_next != S_IDLE;
            o_done     <= w_done;
        end
    end
endmodule
